// File: rtl/kmeans_pkg.sv
// Shared definitions for the Kmeans host streamer: default sizes, data widths
// and the run-controller state encoding.
package kmeans_pkg;

    localparam int unsigned N_WORDS_DEF   = 206;
    localparam int unsigned N_RESULTS_DEF = 100;
    localparam int unsigned AW_DEF        = 8;
    localparam int unsigned RAW_DEF       = 7;
    localparam int unsigned TIMEOUT_DEF   = 1023;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LABEL_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_SEND  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

endpackage

// File: rtl/kmeans_stream_host_if.sv
// Signal bundle between the Kmeans host streamer and its environment
// (source memory, Kmeans core, result memory, run control).
//   start                 run request
//   mem_addr / mem_rdata  source-memory read port
//   IN_VALID / IN_DATA    word stream toward the core, stalled by busy
//   OUT_VALID / OUT_DATA  cluster labels from the core
//   res_we/addr/data      result-memory write port
//   done/timeout/overflow run status
// master = host streamer, slave = environment.
interface kmeans_stream_host_if
    import kmeans_pkg::*;
#(
    parameter int unsigned AW  = AW_DEF,
    parameter int unsigned RAW = RAW_DEF
);

    logic                start;
    logic [AW-1:0]       mem_addr;
    logic [DATA_W-1:0]   mem_rdata;
    logic                IN_VALID;
    logic [DATA_W-1:0]   IN_DATA;
    logic                busy;
    logic                OUT_VALID;
    logic [LABEL_W-1:0]  OUT_DATA;
    logic                res_we;
    logic [RAW-1:0]      res_addr;
    logic [LABEL_W-1:0]  res_data;
    logic                done;
    logic                timeout;
    logic                overflow;

    modport master (
        input  start, mem_rdata, busy, OUT_VALID, OUT_DATA,
        output mem_addr, IN_VALID, IN_DATA, res_we, res_addr, res_data,
               done, timeout, overflow
    );

    modport slave (
        output start, mem_rdata, busy, OUT_VALID, OUT_DATA,
        input  mem_addr, IN_VALID, IN_DATA, res_we, res_addr, res_data,
               done, timeout, overflow
    );

endinterface

// File: rtl/kmeans_result_capture.sv
// Captures cluster labels from the core into the result memory, counts them,
// tracks idle cycles while waiting for labels and flags surplus labels.
//   clk, rst     clock, async active-high reset
//   clear        accepted start: zero counters and overflow
//   active       run in PRIME/SEND/WAIT; labels outside are ignored
//   in_wait      run in WAIT; enables the idle counter
//   out_valid    label strobe from the core
//   out_data     label value
//   res_we/addr/data  registered result-memory write
//   overflow     sticky: label seen after the result memory was full
//   full_c       all labels of the run received
//   expired_c    idle counter reached its limit
module kmeans_result_capture
    import kmeans_pkg::*;
#(
    parameter int unsigned N_RESULTS = N_RESULTS_DEF,
    parameter int unsigned RAW       = RAW_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               active,
    input  logic               in_wait,
    input  logic               out_valid,
    input  logic [LABEL_W-1:0] out_data,
    output logic               res_we,
    output logic [RAW-1:0]     res_addr,
    output logic [LABEL_W-1:0] res_data,
    output logic               overflow,
    output logic               full_c,
    output logic               expired_c
);

    localparam int unsigned CW = RAW + 1;
    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] out_cnt;
    logic [IW-1:0] idle_cnt;

    assign full_c    = (out_cnt == CW'(N_RESULTS));
    assign expired_c = (idle_cnt == IW'(TIMEOUT));

    // Label write, counting, overflow and idle tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt  <= '0;
            idle_cnt <= '0;
            res_we   <= 1'b0;
            res_addr <= '0;
            res_data <= '0;
            overflow <= 1'b0;
        end else begin
            res_we <= 1'b0;
            if (clear) begin
                out_cnt  <= '0;
                idle_cnt <= '0;
                overflow <= 1'b0;
            end else if (active) begin
                if (out_valid) begin
                    idle_cnt <= '0;
                    if (full_c) begin
                        overflow <= 1'b1;
                    end else begin
                        res_we   <= 1'b1;
                        res_addr <= out_cnt[RAW-1:0];
                        res_data <= out_data;
                        out_cnt  <= out_cnt + CW'(1);
                    end
                end else if (in_wait && !expired_c) begin
                    idle_cnt <= idle_cnt + IW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/kmeans_stream_host.sv
// Host-side streamer for the Kmeans core: on start, reads N_WORDS words from a
// synchronous-read source memory and streams them to the core under busy
// back-pressure, while capturing the returned labels; pulses done when all
// labels are in or the core has gone quiet for TIMEOUT cycles.
//   CLK, RESET   clock, async active-high reset
//   bus          kmeans_stream_host_if master port (memory, core, results, status)
module kmeans_stream_host
    import kmeans_pkg::*;
#(
    parameter int unsigned N_WORDS   = N_WORDS_DEF,
    parameter int unsigned N_RESULTS = N_RESULTS_DEF,
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned RAW       = RAW_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                 CLK,
    input  logic                 RESET,
    kmeans_stream_host_if.master bus
);

    state_t        state, state_n;
    logic [AW-1:0] ptr, ptr_n;
    logic          in_valid_n, done_n, timeout_n;
    logic          fire_c, last_c, accept_c, active_c, full_c, expired_c;

    assign fire_c   = bus.IN_VALID && !bus.busy;
    assign last_c   = (ptr == AW'(N_WORDS - 1));
    assign accept_c = (state == ST_IDLE) && bus.start;
    assign active_c = (state == ST_PRIME) || (state == ST_SEND) || (state == ST_WAIT);

    // Look one word ahead on a transfer so mem_rdata always holds word ptr
    assign bus.mem_addr = fire_c ? ptr + AW'(1) : ptr;
    assign bus.IN_DATA  = bus.IN_VALID ? bus.mem_rdata : '0;

    // Run controller state and registered outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            bus.IN_VALID <= 1'b0;
            bus.done     <= 1'b0;
            bus.timeout  <= 1'b0;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            bus.IN_VALID <= in_valid_n;
            bus.done     <= done_n;
            bus.timeout  <= timeout_n;
        end
    end

    // Next state; IN_VALID and done are registered images of the next state
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        timeout_n = bus.timeout;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_n   = ST_PRIME;
                    ptr_n     = '0;
                    timeout_n = 1'b0;
                end
            end
            ST_PRIME: state_n = ST_SEND;
            ST_SEND: begin
                if (fire_c) begin
                    if (last_c) state_n = ST_WAIT;
                    else        ptr_n   = ptr + AW'(1);
                end
            end
            ST_WAIT: begin
                if (full_c) begin
                    state_n = ST_FIN;
                end else if (expired_c) begin
                    state_n   = ST_FIN;
                    timeout_n = 1'b1;
                end
            end
            ST_FIN:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        in_valid_n = (state_n == ST_SEND);
        done_n     = (state_n == ST_FIN);
    end

    kmeans_result_capture #(
        .N_RESULTS (N_RESULTS),
        .RAW       (RAW),
        .TIMEOUT   (TIMEOUT)
    ) u_capture (
        .clk       (CLK),
        .rst       (RESET),
        .clear     (accept_c),
        .active    (active_c),
        .in_wait   (state == ST_WAIT),
        .out_valid (bus.OUT_VALID),
        .out_data  (bus.OUT_DATA),
        .res_we    (bus.res_we),
        .res_addr  (bus.res_addr),
        .res_data  (bus.res_data),
        .overflow  (bus.overflow),
        .full_c    (full_c),
        .expired_c (expired_c)
    );

endmodule
